conv_acc_fp16: RTL
==================

# conv_acc_fp16

FP16 channel accumulator that sits directly downstream of the 9-input FP16 adder tree in the convolution datapath. Each adder-tree output is the 3×3 partial sum for one input channel; this block adds a per-output bias, accumulates `cfg_num_ch` consecutive partial sums, and presents one finished output pixel on a valid/ready port. Results go to the output writeback buffer.

## Interface
- No parameters; the data width is fixed at FP16 (16 bits).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous abort; discards any partial accumulation.
- `cfg_num_ch` in 8: input channels per output pixel; 0 is treated as 1.
- `cfg_bias` in 16: FP16 bias added once per output pixel.
- `in_valid` in 1: `in_data` carries a partial sum; already aligned to the adder-tree output register stage.
- `in_ready` out 1: the block accepts `in_data` this cycle.
- `in_data` in 16: FP16 per-channel partial sum.
- `out_valid` out 1: `out_data` holds a finished pixel.
- `out_ready` in 1: the consumer takes `out_data`.
- `out_data` out 16: FP16 accumulated pixel (after ReLU when enabled).
- `busy` out 1: a pixel is partially accumulated (`cnt != 0`).

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Registers:
  - `acc[15:0]`: running sum.
  - `cnt[7:0]`: beats accepted for the current pixel.
  - `nch[7:0]`: latched channel count.
  - `out_valid`, `out_data`: output holding register.
- Addend selection:
  - On the first beat (`cnt==0`): the addend is `cfg_bias`, and `nch` latches `max(cfg_num_ch,1)`.
  - Otherwise: the addend is `acc`.
  - Changes to `cfg_*` mid-pixel have no effect until the next pixel.
- Sum = `float_adder(addend, in_data)`, combinational, same cycle.
- Last beat (`cnt == nch-1`):
  - `out_data <= f(sum)` and `out_valid <= 1`.
  - `cnt <= 0`; `acc` is don't-care.
- Other beats: `acc <= sum`, `cnt <= cnt+1`.
- Backpressure: `in_ready = !out_valid || out_ready`. No accumulation proceeds while an unconsumed result is held.
- Output handshake:
  - `out_valid` clears on `out_ready` unless a new last beat is accepted in the same cycle; in that case it stays 1 and `out_data` is replaced.
  - `out_data` is stable while `out_valid && !out_ready`.
- `clr`:
  - Sets `cnt <= 0` and `out_valid <= 0`; any held result is dropped.
  - A beat presented in the same cycle is ignored; `in_ready` is 0 during `clr`.
- `nch==1`: every beat is a last beat, so the result is `bias + in_data`.
- `cnt` never exceeds 254, so there is no wrap-around.

## Timing
- Reset values: `out_valid=0`, `out_data=16'h0000`, `busy=0`, `acc=0`, `cnt=0`, `nch=1`. `in_ready=1` once out of reset.
- Latency: the last beat is accepted in cycle N; `out_valid=1` in cycle N+1.
- Throughput:
  - One beat per cycle while `out_ready=1`.
  - Back-to-back pixels need no bubble.
- Reset mid-pixel: everything returns to reset values immediately; the partial pixel is lost.

## Configuration
- Macro `CONV_ACC_RELU_EN` defined:
  - `f(x) = x[15] ? 16'h0000 : x`.
  - Every sign-set value maps to `16'h0000`, including -0 and negative NaN.
- Macro not defined: `f(x) = x`, a pure pass-through.

## Structure
- Shared package `acc_pkg`:
  - FP16 width constant.
  - Constants `FP16_ZERO=16'h0000` and `FP16_ONE=16'h3C00`.
  - Channel-count width constant (8).
- Exactly one sub-module: the existing combinational `float_adder` (ports `num1`, `num2`, `result`), instantiated once.
- No local FSM module; the state is `cnt` together with `out_valid`.

## Test plan
- `cfg_num_ch=3`, `bias=3C00`, three beats of `3C00` with `out_ready=1` → one `out_valid` pulse one cycle after the third beat, with `out_data=4400` (4.0).
- `cfg_num_ch=0`, `bias=3800`, beats `3C00` then `4000` → two results, `3E00` (1.5) then `4100` (2.5), each 1 cycle after its beat.
- Hold `out_ready=0` after pixel 1 (`nch=2`, `bias=0000`, beats `3C00`,`3C00`) → `out_data=4000` held stable and `in_ready=0`. Release `out_ready` → pixel 2 accepted with no lost beat.
- Negative result: `nch=1`, `bias=BC00`, beat `3800` → `B800` without `CONV_ACC_RELU_EN` and `0000` with it.
- Abort: `nch=4`, two beats accepted (`busy=1`), then assert `clr` → `busy=0` and no output. A fresh pixel (`nch=1`, `bias=0000`, beat `4200`) → `4200`.
- Async reset mid-pixel and while `out_valid=1` → all outputs at reset values without a clock edge. The next pixel after release computes correctly.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared constants for the FP16 channel accumulator.
// Widths and FP16 encodings used by conv_acc_fp16 and float_adder.
package acc_pkg;
   localparam int FP16_W = 16;
   localparam int CH_W   = 8;
   localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
   localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
endpackage

// File: rtl/float_adder.sv
// Combinational FP16 adder, round-to-nearest-even.
// Subnormals are kept; NaN results use the canonical quiet 7E00.
module float_adder
   import acc_pkg::*;
(
   input  logic [FP16_W-1:0] num1,
   input  logic [FP16_W-1:0] num2,
   output logic [FP16_W-1:0] result
);
   logic        swap;
   logic [15:0] a, b;
   logic [4:0]  ea, eb, d;
   logic [10:0] ma, mb;
   logic [13:0] xa, xb;
   logic [27:0] sh;
   logic [14:0] s;
   logic [5:0]  e;
   logic [13:0] n;
   logic [11:0] r;
   logic        inc;

   always_comb begin
      swap = num2[14:0] > num1[14:0];
      a    = swap ? num2 : num1;
      b    = swap ? num1 : num2;
      ea   = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
      eb   = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
      ma   = {a[14:10] != 5'd0, a[9:0]};
      mb   = {b[14:10] != 5'd0, b[9:0]};
      d    = ea - eb;
      xa   = {ma, 3'b000};
      sh   = {mb, 3'b000, 14'd0} >> d;
      // three extra low bits: guard, round, sticky
      xb   = (d > 5'd13) ? {13'd0, |mb}
                         : (sh[27:14] | {13'd0, |sh[13:0]});
      s    = (a[15] == b[15]) ? ({1'b0, xa} + {1'b0, xb})
                              : ({1'b0, xa} - {1'b0, xb});
      e    = {1'b0, ea};
      if (s[14]) begin
         n = {s[14:2], s[1] | s[0]};
         e = e + 6'd1;
      end else begin
         n = s[13:0];
         for (int i = 0; i < 13; i++) begin
            if (!n[13] && e > 6'd1) begin
               n = n << 1;
               e = e - 6'd1;
            end
         end
      end
      inc = n[2] & (n[1] | n[0] | n[3]);
      r   = {1'b0, n[13:3]} + {11'd0, inc};
      if (r[11]) begin
         r = 12'h400;
         e = e + 6'd1;
      end
      if (e >= 6'd31)
         result = {a[15], 5'h1F, 10'd0};
      else
         result = {a[15], r[10] ? e[4:0] : 5'd0, r[9:0]};
      if (s == 15'd0)
         result = {a[15] & b[15], 15'd0};
      if (a[14:10] == 5'h1F) begin
         if (a[9:0] != 10'd0 ||
             (b[14:10] == 5'h1F && a[15] != b[15]))
            result = 16'h7E00;
         else
            result = a;
      end
   end
endmodule

// File: rtl/conv_acc_fp16.sv
// Per-pixel FP16 channel accumulator with bias and valid/ready output.
// Define CONV_ACC_RELU_EN to clamp sign-set results to +0.
module conv_acc_fp16
   import acc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [CH_W-1:0]   cfg_num_ch,
   input  logic [FP16_W-1:0] cfg_bias,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FP16_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP16_W-1:0] out_data,
   output logic              busy
);
   logic [FP16_W-1:0] acc_q, acc_d, out_q, out_d;
   logic [FP16_W-1:0] addend, sum, res;
   logic [CH_W-1:0]   cnt_q, cnt_d, nch_q, nch_d, nch_cur;
   logic              ov_q, ov_d;
   logic              fire, first, last;

   float_adder u_add (
      .num1   (addend),
      .num2   (in_data),
      .result (sum)
   );

`ifdef CONV_ACC_RELU_EN
   assign res = sum[15] ? FP16_ZERO : sum;
`else
   assign res = sum;
`endif

   assign in_ready  = !clr && (!ov_q || out_ready);
   assign fire      = in_valid && in_ready;
   assign first     = cnt_q == '0;
   // config is only sampled on the first beat of a pixel
   assign nch_cur   = first ? ((cfg_num_ch == '0) ? 8'd1 : cfg_num_ch)
                            : nch_q;
   assign last      = cnt_q == nch_cur - 8'd1;
   assign addend    = first ? cfg_bias : acc_q;
   assign out_valid = ov_q;
   assign out_data  = out_q;
   assign busy      = cnt_q != '0;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      nch_d = nch_q;
      out_d = out_q;
      ov_d  = ov_q;
      if (ov_q && out_ready)
         ov_d = 1'b0;
      if (fire) begin
         nch_d = nch_cur;
         if (last) begin
            out_d = res;
            ov_d  = 1'b1;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 8'd1;
         end
      end
      if (clr) begin
         cnt_d = '0;
         ov_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= FP16_ZERO;
         out_q <= FP16_ZERO;
         cnt_q <= '0;
         nch_q <= 8'd1;
         ov_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
         cnt_q <= cnt_d;
         nch_q <= nch_d;
         ov_q  <= ov_d;
      end
   end
endmodule
